alu_issue_stage: RTL and testbench
==================================

Name: alu_issue_stage

Overview:
- Decode-side producer for the 32-bit execute ALU.
- Decodes a MIPS instruction into the ALU's 4-bit control code.
- Selects and extends the operands, computes the writeback destination and trap enable.
- Registers everything into the ID/EX pipeline register, with stall/flush/valid handshaking. Sits between the register file read and the ALU.

Parameters:
DATA_WIDTH, 32, operand width (matches ALU DATA_WIDTH)

Ports:
clk  in  1  clock; all state on rising edge
rst  in  1  asynchronous, active-high reset
id_valid  in  1  decode slot holds a real instruction
id_instr  in  32  instruction word
id_rs_data  in  DATA_WIDTH  register file value for rs
id_rt_data  in  DATA_WIDTH  register file value for rt
ex_stall  in  1  execute cannot accept; hold register
ex_flush  in  1  squash instruction being written into register
id_ready  out  1  = !ex_stall (combinational)
ex_valid  out  1  register holds a live instruction
ex_alu_control  out  4  ALU control code
ex_rega  out  DATA_WIDTH  ALU rega operand
ex_regb  out  DATA_WIDTH  ALU regb operand
ex_dest  out  5  writeback register
ex_reg_write  out  1  writeback enable
ex_ovf_en  out  1  ALU overflow flag raises a trap
ex_branch_ne  out  1  branch on !equal (bne) rather than equal
ex_illegal  out  1  unsupported opcode/funct

Behaviour:
Reset and register control:
- Reset (async, any time, including mid-stall): all outputs 0; the in-flight instruction is discarded.
- Latency: 1 cycle from accepted id_* to ex_*.
- Priority each edge: ex_flush > ex_stall > load.
- Flush: ex_valid<=0 and all other outputs <=0, even if ex_stall=1.
- Stall: all ex_* hold their values.
- Load: ex_valid<=id_valid. Decoded fields load only when id_valid=1. When id_valid=0, ex_reg_write, ex_ovf_en and ex_illegal are forced 0.

ALU codes:
ADD0 SUB1 AND2 OR3 XOR4 SLLV5 SRLV6 SLT7 NOR8 SLTU9 SLL10 COMP11 SRAV12 SUBU13 ADDU14 SRL15.

R-type (opcode 0x00):
- Common: dest=rd, reg_write=1, rega=rs, regb=rt, unless noted.
- funct 20 add ADD ovf_en=1; 21 addu ADDU; 22 sub SUB ovf_en=1; 23 subu SUBU.
- funct 24 AND; 25 OR; 26 XOR; 27 NOR; 2A SLT; 2B SLTU.
- funct 00 sll SLL, 02 srl SRL, 03 sra SRAV: rega=rt, regb=zero-extended shamt.
- funct 04 sllv SLLV, 06 srlv SRLV, 07 srav SRAV: rega=rt, regb=rs (the ALU masks the amount).

I-type:
- Common: dest=rt, reg_write=1, rega=rs.
- Sign-extended imm: 08 addi ADD ovf_en=1; 09 addiu ADDU; 0A slti SLT; 0B sltiu SLTU.
- Zero-extended imm: 0C andi AND; 0D ori OR; 0E xori XOR.
- 0F lui: SLL, rega=zero-extended imm, regb=16.
- 23 lw: ADDU, regb=sign-extended imm.
- 2B sw: ADDU, regb=sign-extended imm, reg_write=0, dest=0.
- 04 beq / 05 bne: COMP, rega=rs, regb=rt, reg_write=0, dest=0, branch_ne=(opcode==05).

Illegal and side-effect rules:
- Any other opcode/funct: ex_illegal=1, control=ADD, operands 0, reg_write=0, ex_valid still follows id_valid.
- Destination 0: reg_write forced 0.
- ovf_en is 1 only for add/sub/addi.

Decomposition:
- Shared package mips_pkg holds:
  - ALU control localparams (names above, 4 bits), reused by the ALU and its bench;
  - opcode and funct localparams;
  - field-slice constants: rs 25:21, rt 20:16, rd 15:11, shamt 10:6, imm 15:0.
- One sub-module, alu_decode: purely combinational decode of id_instr to control code, operand selects, dest, flags.
- The top holds operand muxing/extension and the ID/EX register.

Test Plan:
- addi: id_instr=0x2128FFFF, rs_data=5, id_valid=1 -> next cycle ex_valid=1, control=0, rega=5, regb=0xFFFFFFFF, dest=8, reg_write=1, ovf_en=1.
- sll and lui:
  - 0x00094100 with rt_data=1 -> control=10, rega=1, regb=4, dest=8.
  - 0x3C081234 -> control=10, rega=0x1234, regb=16, dest=8.
- bne: 0x14220003, rs_data=7, rt_data=7 -> control=11, rega=7, regb=7, reg_write=0, dest=0, branch_ne=1. Repeat with 0x10220003 -> branch_ne=0.
- Stall then flush:
  - Load addu; raise ex_stall for 3 cycles while changing id_instr -> outputs frozen, id_ready=0.
  - Then ex_stall=1 and ex_flush=1 together -> next cycle ex_valid=0, all outputs 0.
- Illegal and edge cases:
  - Opcode 0x3F -> ex_illegal=1, ex_valid=1, reg_write=0.
  - R-type add with rd=0 -> reg_write=0.
  - id_valid=0 -> ex_valid=0, reg_write=0.
- Reset: assert rst between clock edges while ex_valid=1 -> outputs go 0 immediately, without waiting for clk; first load after release matches decode.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS decode constants: ALU control codes, opcode/funct values,
// instruction field positions and the decode bundle passed to the issue stage.
package mips_pkg;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_SLLV = 4'd5;
  localparam logic [3:0] ALU_SRLV = 4'd6;
  localparam logic [3:0] ALU_SLT  = 4'd7;
  localparam logic [3:0] ALU_NOR  = 4'd8;
  localparam logic [3:0] ALU_SLTU = 4'd9;
  localparam logic [3:0] ALU_SLL  = 4'd10;
  localparam logic [3:0] ALU_COMP = 4'd11;
  localparam logic [3:0] ALU_SRAV = 4'd12;
  localparam logic [3:0] ALU_SUBU = 4'd13;
  localparam logic [3:0] ALU_ADDU = 4'd14;
  localparam logic [3:0] ALU_SRL  = 4'd15;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] F_SLL  = 6'h00;
  localparam logic [5:0] F_SRL  = 6'h02;
  localparam logic [5:0] F_SRA  = 6'h03;
  localparam logic [5:0] F_SLLV = 6'h04;
  localparam logic [5:0] F_SRLV = 6'h06;
  localparam logic [5:0] F_SRAV = 6'h07;
  localparam logic [5:0] F_ADD  = 6'h20;
  localparam logic [5:0] F_ADDU = 6'h21;
  localparam logic [5:0] F_SUB  = 6'h22;
  localparam logic [5:0] F_SUBU = 6'h23;
  localparam logic [5:0] F_AND  = 6'h24;
  localparam logic [5:0] F_OR   = 6'h25;
  localparam logic [5:0] F_XOR  = 6'h26;
  localparam logic [5:0] F_NOR  = 6'h27;
  localparam logic [5:0] F_SLT  = 6'h2A;
  localparam logic [5:0] F_SLTU = 6'h2B;

  localparam int OP_HI    = 31;
  localparam int OP_LO    = 26;
  localparam int RS_HI    = 25;
  localparam int RS_LO    = 21;
  localparam int RT_HI    = 20;
  localparam int RT_LO    = 16;
  localparam int RD_HI    = 15;
  localparam int RD_LO    = 11;
  localparam int SHAMT_HI = 10;
  localparam int SHAMT_LO = 6;
  localparam int IMM_HI   = 15;
  localparam int IMM_LO   = 0;
  localparam int FUNCT_HI = 5;
  localparam int FUNCT_LO = 0;

  typedef enum logic [1:0] {
    A_ZERO,
    A_RS,
    A_RT,
    A_IMM_ZX
  } rega_sel_e;

  typedef enum logic [2:0] {
    B_ZERO,
    B_RS,
    B_RT,
    B_SHAMT,
    B_IMM_SX,
    B_IMM_ZX,
    B_CONST16
  } regb_sel_e;

  typedef struct packed {
    logic [3:0] alu_control;
    rega_sel_e  rega_sel;
    regb_sel_e  regb_sel;
    logic [4:0] dest;
    logic       reg_write;
    logic       ovf_en;
    logic       branch_ne;
    logic       illegal;
  } decode_t;

endpackage

// File: rtl/alu_decode.sv
// Combinational MIPS decode: ALU control code, operand source selects,
// writeback destination and side-effect flags.
module alu_decode
  import mips_pkg::*;
(
  input  logic [31:0] instr,
  output decode_t     dec
);

  logic [5:0] op;
  logic [5:0] funct;
  logic [4:0] rt;
  logic [4:0] rd;
  logic       bad;

  assign op    = instr[OP_HI:OP_LO];
  assign funct = instr[FUNCT_HI:FUNCT_LO];
  assign rt    = instr[RT_HI:RT_LO];
  assign rd    = instr[RD_HI:RD_LO];

  // rs and shamt only steer data in the top-level operand muxes
  logic unused_fields;
  assign unused_fields = ^{instr[RS_HI:RS_LO], instr[SHAMT_HI:SHAMT_LO]};

  always_comb begin
    dec             = '0;
    dec.alu_control = ALU_ADD;
    dec.rega_sel    = A_RS;
    dec.regb_sel    = B_RT;
    bad             = 1'b0;
    unique case (op)
      OP_RTYPE: begin
        dec.dest      = rd;
        dec.reg_write = 1'b1;
        case (funct)
          F_ADD:  begin dec.alu_control = ALU_ADD; dec.ovf_en = 1'b1; end
          F_ADDU: dec.alu_control = ALU_ADDU;
          F_SUB:  begin dec.alu_control = ALU_SUB; dec.ovf_en = 1'b1; end
          F_SUBU: dec.alu_control = ALU_SUBU;
          F_AND:  dec.alu_control = ALU_AND;
          F_OR:   dec.alu_control = ALU_OR;
          F_XOR:  dec.alu_control = ALU_XOR;
          F_NOR:  dec.alu_control = ALU_NOR;
          F_SLT:  dec.alu_control = ALU_SLT;
          F_SLTU: dec.alu_control = ALU_SLTU;
          F_SLL:  begin dec.alu_control = ALU_SLL;  dec.rega_sel = A_RT; dec.regb_sel = B_SHAMT; end
          F_SRL:  begin dec.alu_control = ALU_SRL;  dec.rega_sel = A_RT; dec.regb_sel = B_SHAMT; end
          F_SRA:  begin dec.alu_control = ALU_SRAV; dec.rega_sel = A_RT; dec.regb_sel = B_SHAMT; end
          F_SLLV: begin dec.alu_control = ALU_SLLV; dec.rega_sel = A_RT; dec.regb_sel = B_RS; end
          F_SRLV: begin dec.alu_control = ALU_SRLV; dec.rega_sel = A_RT; dec.regb_sel = B_RS; end
          F_SRAV: begin dec.alu_control = ALU_SRAV; dec.rega_sel = A_RT; dec.regb_sel = B_RS; end
          default: bad = 1'b1;
        endcase
      end
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI,
      OP_LUI, OP_LW: begin
        dec.dest      = rt;
        dec.reg_write = 1'b1;
        dec.regb_sel  = B_IMM_SX;
        case (op)
          OP_ADDI:  begin dec.alu_control = ALU_ADD; dec.ovf_en = 1'b1; end
          OP_ADDIU: dec.alu_control = ALU_ADDU;
          OP_SLTI:  dec.alu_control = ALU_SLT;
          OP_SLTIU: dec.alu_control = ALU_SLTU;
          OP_ANDI:  begin dec.alu_control = ALU_AND; dec.regb_sel = B_IMM_ZX; end
          OP_ORI:   begin dec.alu_control = ALU_OR;  dec.regb_sel = B_IMM_ZX; end
          OP_XORI:  begin dec.alu_control = ALU_XOR; dec.regb_sel = B_IMM_ZX; end
          OP_LUI:   begin
            dec.alu_control = ALU_SLL;
            dec.rega_sel    = A_IMM_ZX;
            dec.regb_sel    = B_CONST16;
          end
          default:  dec.alu_control = ALU_ADDU;
        endcase
      end
      OP_SW: begin
        dec.alu_control = ALU_ADDU;
        dec.regb_sel    = B_IMM_SX;
      end
      OP_BEQ, OP_BNE: begin
        dec.alu_control = ALU_COMP;
        dec.branch_ne   = (op == OP_BNE);
      end
      default: bad = 1'b1;
    endcase

    if (bad) begin
      dec             = '0;
      dec.alu_control = ALU_ADD;
      dec.rega_sel    = A_ZERO;
      dec.regb_sel    = B_ZERO;
      dec.illegal     = 1'b1;
    end
    // register 0 is hardwired; never request a write to it
    if (dec.dest == 5'd0) dec.reg_write = 1'b0;
  end

endmodule

// File: rtl/alu_issue_stage.sv
// Decode-side issue stage: decodes, builds ALU operands and registers the
// result into the ID/EX pipeline register with stall/flush control.
module alu_issue_stage
  import mips_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid,
  input  logic [31:0]           id_instr,
  input  logic [DATA_WIDTH-1:0] id_rs_data,
  input  logic [DATA_WIDTH-1:0] id_rt_data,
  input  logic                  ex_stall,
  input  logic                  ex_flush,
  output logic                  id_ready,
  output logic                  ex_valid,
  output logic [3:0]            ex_alu_control,
  output logic [DATA_WIDTH-1:0] ex_rega,
  output logic [DATA_WIDTH-1:0] ex_regb,
  output logic [4:0]            ex_dest,
  output logic                  ex_reg_write,
  output logic                  ex_ovf_en,
  output logic                  ex_branch_ne,
  output logic                  ex_illegal
);

  decode_t               dec;
  logic [DATA_WIDTH-1:0] imm_sx;
  logic [DATA_WIDTH-1:0] imm_zx;
  logic [DATA_WIDTH-1:0] shamt_zx;
  logic [DATA_WIDTH-1:0] rega;
  logic [DATA_WIDTH-1:0] regb;

  alu_decode u_decode (
    .instr (id_instr),
    .dec   (dec)
  );

  assign id_ready = !ex_stall;

  assign imm_sx   = {{(DATA_WIDTH-16){id_instr[IMM_HI]}}, id_instr[IMM_HI:IMM_LO]};
  assign imm_zx   = {{(DATA_WIDTH-16){1'b0}}, id_instr[IMM_HI:IMM_LO]};
  assign shamt_zx = {{(DATA_WIDTH-5){1'b0}}, id_instr[SHAMT_HI:SHAMT_LO]};

  always_comb begin
    rega = '0;
    unique case (dec.rega_sel)
      A_RS:     rega = id_rs_data;
      A_RT:     rega = id_rt_data;
      A_IMM_ZX: rega = imm_zx;
      default:  rega = '0;
    endcase
  end

  always_comb begin
    regb = '0;
    unique case (dec.regb_sel)
      B_RS:      regb = id_rs_data;
      B_RT:      regb = id_rt_data;
      B_SHAMT:   regb = shamt_zx;
      B_IMM_SX:  regb = imm_sx;
      B_IMM_ZX:  regb = imm_zx;
      B_CONST16: regb = DATA_WIDTH'(16);
      default:   regb = '0;
    endcase
  end

  // A bubble keeps the old operand fields but must not carry side effects.
  always_ff @(posedge clk or posedge rst) begin
    if (rst || ex_flush) begin
      ex_valid       <= 1'b0;
      ex_alu_control <= '0;
      ex_rega        <= '0;
      ex_regb        <= '0;
      ex_dest        <= '0;
      ex_reg_write   <= 1'b0;
      ex_ovf_en      <= 1'b0;
      ex_branch_ne   <= 1'b0;
      ex_illegal     <= 1'b0;
    end else if (!ex_stall) begin
      ex_valid <= id_valid;
      if (id_valid) begin
        ex_alu_control <= dec.alu_control;
        ex_rega        <= rega;
        ex_regb        <= regb;
        ex_dest        <= dec.dest;
        ex_reg_write   <= dec.reg_write;
        ex_ovf_en      <= dec.ovf_en;
        ex_branch_ne   <= dec.branch_ne;
        ex_illegal     <= dec.illegal;
      end else begin
        ex_reg_write <= 1'b0;
        ex_ovf_en    <= 1'b0;
        ex_illegal   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: instruction-level reference model compared every
// cycle, plus directed vectors with hand-computed expectations.
module tb_alu_issue_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [31:0] id_rs_data;
  logic [31:0] id_rt_data;
  logic        ex_stall;
  logic        ex_flush;
  logic        id_ready;
  logic        ex_valid;
  logic [3:0]  ex_alu_control;
  logic [31:0] ex_rega;
  logic [31:0] ex_regb;
  logic [4:0]  ex_dest;
  logic        ex_reg_write;
  logic        ex_ovf_en;
  logic        ex_branch_ne;
  logic        ex_illegal;

  int checks = 0;
  int errors = 0;

  alu_issue_stage #(.DATA_WIDTH(32)) dut (
    .clk            (clk),
    .rst            (rst),
    .id_valid       (id_valid),
    .id_instr       (id_instr),
    .id_rs_data     (id_rs_data),
    .id_rt_data     (id_rt_data),
    .ex_stall       (ex_stall),
    .ex_flush       (ex_flush),
    .id_ready       (id_ready),
    .ex_valid       (ex_valid),
    .ex_alu_control (ex_alu_control),
    .ex_rega        (ex_rega),
    .ex_regb        (ex_regb),
    .ex_dest        (ex_dest),
    .ex_reg_write   (ex_reg_write),
    .ex_ovf_en      (ex_ovf_en),
    .ex_branch_ne   (ex_branch_ne),
    .ex_illegal     (ex_illegal)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        valid;
    logic [3:0]  ctrl;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  dest;
    logic        rw;
    logic        ovf;
    logic        bne;
    logic        ill;
  } exp_t;

  exp_t m = '0;

  // What the instruction means to the ALU, in operand values.
  function automatic exp_t model_decode(logic [31:0] i, logic [31:0] rsd, logic [31:0] rtd);
    exp_t        e;
    logic [5:0]  op;
    logic [31:0] sx;
    logic [31:0] zx;
    logic [31:0] sh;
    logic        ill;
    op  = i[31:26];
    sx  = {{16{i[15]}}, i[15:0]};
    zx  = {16'h0, i[15:0]};
    sh  = {27'h0, i[10:6]};
    ill = 1'b0;
    e   = '0;
    e.valid = 1'b1;
    if (op == 6'h00) begin
      e.dest = i[15:11]; e.rw = 1'b1; e.a = rsd; e.b = rtd;
      case (i[5:0])
        6'h20: begin e.ctrl = 4'd0; e.ovf = 1'b1; end
        6'h21: e.ctrl = 4'd14;
        6'h22: begin e.ctrl = 4'd1; e.ovf = 1'b1; end
        6'h23: e.ctrl = 4'd13;
        6'h24: e.ctrl = 4'd2;
        6'h25: e.ctrl = 4'd3;
        6'h26: e.ctrl = 4'd4;
        6'h27: e.ctrl = 4'd8;
        6'h2A: e.ctrl = 4'd7;
        6'h2B: e.ctrl = 4'd9;
        6'h00: begin e.ctrl = 4'd10; e.a = rtd; e.b = sh; end
        6'h02: begin e.ctrl = 4'd15; e.a = rtd; e.b = sh; end
        6'h03: begin e.ctrl = 4'd12; e.a = rtd; e.b = sh; end
        6'h04: begin e.ctrl = 4'd5;  e.a = rtd; e.b = rsd; end
        6'h06: begin e.ctrl = 4'd6;  e.a = rtd; e.b = rsd; end
        6'h07: begin e.ctrl = 4'd12; e.a = rtd; e.b = rsd; end
        default: ill = 1'b1;
      endcase
    end else begin
      e.dest = i[20:16]; e.rw = 1'b1; e.a = rsd;
      case (op)
        6'h08: begin e.ctrl = 4'd0;  e.b = sx; e.ovf = 1'b1; end
        6'h09: begin e.ctrl = 4'd14; e.b = sx; end
        6'h0A: begin e.ctrl = 4'd7;  e.b = sx; end
        6'h0B: begin e.ctrl = 4'd9;  e.b = sx; end
        6'h0C: begin e.ctrl = 4'd2;  e.b = zx; end
        6'h0D: begin e.ctrl = 4'd3;  e.b = zx; end
        6'h0E: begin e.ctrl = 4'd4;  e.b = zx; end
        6'h0F: begin e.ctrl = 4'd10; e.a = zx; e.b = 32'd16; end
        6'h23: begin e.ctrl = 4'd14; e.b = sx; end
        6'h2B: begin e.ctrl = 4'd14; e.b = sx; e.rw = 1'b0; e.dest = 5'd0; end
        6'h04, 6'h05: begin
          e.ctrl = 4'd11; e.b = rtd; e.rw = 1'b0; e.dest = 5'd0;
          e.bne = (op == 6'h05);
        end
        default: ill = 1'b1;
      endcase
    end
    if (ill) begin
      e = '0; e.valid = 1'b1; e.ill = 1'b1;
    end
    if (e.dest == 5'd0) e.rw = 1'b0;
    return e;
  endfunction

  // Pipeline register model: flush beats stall beats load.
  always @(posedge clk or posedge rst) begin
    if (rst || ex_flush) begin
      m <= '0;
    end else if (!ex_stall) begin
      if (id_valid) begin
        m <= model_decode(id_instr, id_rs_data, id_rt_data);
      end else begin
        m.valid <= 1'b0;
        m.rw    <= 1'b0;
        m.ovf   <= 1'b0;
        m.ill   <= 1'b0;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("model_valid", 32'(ex_valid), 32'(m.valid));
    chk("model_ctrl",  32'(ex_alu_control), 32'(m.ctrl));
    chk("model_rega",  ex_rega, m.a);
    chk("model_regb",  ex_regb, m.b);
    chk("model_dest",  32'(ex_dest), 32'(m.dest));
    chk("model_rw",    32'(ex_reg_write), 32'(m.rw));
    chk("model_ovf",   32'(ex_ovf_en), 32'(m.ovf));
    chk("model_bne",   32'(ex_branch_ne), 32'(m.bne));
    chk("model_ill",   32'(ex_illegal), 32'(m.ill));
    chk("model_ready", 32'(id_ready), 32'(!ex_stall));
  end

  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] rsd,
                       input logic [31:0] rtd);
    id_valid   = v;
    id_instr   = ins;
    id_rs_data = rsd;
    id_rt_data = rtd;
    ex_stall   = 1'b0;
    ex_flush   = 1'b0;
  endtask

  task automatic lit(input string tag, input logic v, input logic [3:0] c, input logic [31:0] a,
                     input logic [31:0] b, input logic [4:0] d, input logic rw,
                     input logic ovf, input logic bne, input logic ill);
    chk({tag, "_valid"}, 32'(ex_valid), 32'(v));
    chk({tag, "_ctrl"},  32'(ex_alu_control), 32'(c));
    chk({tag, "_rega"},  ex_rega, a);
    chk({tag, "_regb"},  ex_regb, b);
    chk({tag, "_dest"},  32'(ex_dest), 32'(d));
    chk({tag, "_rw"},    32'(ex_reg_write), 32'(rw));
    chk({tag, "_ovf"},   32'(ex_ovf_en), 32'(ovf));
    chk({tag, "_bne"},   32'(ex_branch_ne), 32'(bne));
    chk({tag, "_ill"},   32'(ex_illegal), 32'(ill));
  endtask

  logic [31:0] extra [10] = '{
    32'hAD09FFF0,  // sw  $9, -16($8)
    32'h8D09FFF0,  // lw  $9, -16($8)
    32'h00095083,  // sra $10, $9, 2
    32'h01095007,  // srav $10, $9, $8
    32'h2909FFFF,  // slti $9, $8, -1
    32'h3109F0F0,  // andi $9, $8, 0xF0F0
    32'h3909800F,  // xori $9, $8, 0x800F
    32'h01095022,  // sub $10, $8, $9
    32'h0109503F,  // undefined funct
    32'h01095027   // nor $10, $8, $9
  };

  initial begin
    drive(1'b0, 32'h0, 32'h0, 32'h0);
    #1 rst = 1'b1;
    cyc();
    cyc();
    lit("reset", 0, 4'd0, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b0;

    drive(1'b1, 32'h2128FFFF, 32'd5, 32'd0);
    cyc();
    lit("addi", 1, 4'd0, 32'd5, 32'hFFFFFFFF, 5'd8, 1, 1, 0, 0);

    drive(1'b1, 32'h00094100, 32'd0, 32'd1);
    cyc();
    lit("sll", 1, 4'd10, 32'd1, 32'd4, 5'd8, 1, 0, 0, 0);

    drive(1'b1, 32'h3C081234, 32'd0, 32'd0);
    cyc();
    lit("lui", 1, 4'd10, 32'h1234, 32'd16, 5'd8, 1, 0, 0, 0);

    drive(1'b1, 32'h14220003, 32'd7, 32'd7);
    cyc();
    lit("bne", 1, 4'd11, 32'd7, 32'd7, 5'd0, 0, 0, 1, 0);

    drive(1'b1, 32'h10220003, 32'd7, 32'd7);
    cyc();
    lit("beq", 1, 4'd11, 32'd7, 32'd7, 5'd0, 0, 0, 0, 0);

    drive(1'b1, 32'h01095021, 32'd3, 32'd4);
    cyc();
    lit("addu", 1, 4'd14, 32'd3, 32'd4, 5'd10, 1, 0, 0, 0);

    for (int k = 0; k < 3; k++) begin
      ex_stall = 1'b1;
      id_instr = 32'h2128FFFF + 32'(k);
      id_rs_data = 32'(k + 100);
      #1;
      chk("stall_ready", 32'(id_ready), 32'd0);
      cyc();
      lit("stall", 1, 4'd14, 32'd3, 32'd4, 5'd10, 1, 0, 0, 0);
    end

    ex_stall = 1'b1;
    ex_flush = 1'b1;
    cyc();
    lit("flush", 0, 4'd0, 0, 0, 0, 0, 0, 0, 0);

    drive(1'b1, 32'hFC000000, 32'd9, 32'd9);
    cyc();
    lit("illegal", 1, 4'd0, 0, 0, 0, 0, 0, 0, 1);

    drive(1'b1, 32'h01090020, 32'd1, 32'd2);
    cyc();
    lit("add_rd0", 1, 4'd0, 32'd1, 32'd2, 5'd0, 0, 1, 0, 0);

    drive(1'b0, 32'h2128FFFF, 32'd5, 32'd0);
    cyc();
    chk("bubble_valid", 32'(ex_valid), 32'd0);
    chk("bubble_rw", 32'(ex_reg_write), 32'd0);
    chk("bubble_ovf", 32'(ex_ovf_en), 32'd0);

    for (int k = 0; k < 10; k++) begin
      drive(1'b1, extra[k], 32'h8000_0000 + 32'(k), 32'h0000_00F3 + 32'(k));
      cyc();
    end

    drive(1'b1, 32'h01095021, 32'd11, 32'd12);
    ex_flush = 1'b1;
    cyc();
    drive(1'b1, 32'h2128FFFF, 32'd5, 32'd0);
    cyc();
    #2;
    rst = 1'b1;
    #1;
    lit("async_rst", 0, 4'd0, 0, 0, 0, 0, 0, 0, 0);
    cyc();
    rst = 1'b0;
    drive(1'b1, 32'h3C081234, 32'd0, 32'd0);
    cyc();
    lit("post_rst", 1, 4'd10, 32'h1234, 32'd16, 5'd8, 1, 0, 0, 0);

    drive(1'b0, 32'h0, 32'h0, 32'h0);
    cyc();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
